// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one shared memory port.
// One transaction in flight; data wins except after two back-to-back data grants.
module mem_arbiter #(
   parameter int          LATENCY    = 2,
   parameter logic [31:0] DATA_LIMIT = 32'h0000_3000,
   parameter logic [31:0] MEM_SIZE   = 32'h0000_4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_read,
   output logic        m_write,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] LAST = 4'(LATENCY - 1);

   state_t      state, state_nxt;
   logic [1:0]  data_streak;
   logic        owner_d, we_r, err_r;
   logic [3:0]  cnt;
   logic [31:0] rdata_r;
   logic        grant_d, grant_i, d_bad, i_bad, req_err;

   always_comb begin
      grant_d = d_req && !(i_req && data_streak == 2'd2);
      grant_i = i_req && !grant_d;
      d_bad   = (d_addr[1:0] != 2'b00) || (d_addr >= DATA_LIMIT);
      i_bad   = (i_addr[1:0] != 2'b00) || (i_addr < DATA_LIMIT) || (i_addr >= MEM_SIZE);
      req_err = grant_d ? d_bad : i_bad;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_d || grant_i) state_nxt = req_err ? RESP : ACCESS;
         ACCESS:  if (cnt == LAST) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // rdata_r is cleared at grant so writes and rejected accesses return zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_streak <= 2'd0;
         owner_d     <= 1'b0;
         we_r        <= 1'b0;
         err_r       <= 1'b0;
         cnt         <= 4'd0;
         rdata_r     <= 32'd0;
         m_addr      <= 32'd0;
         m_wdata     <= 32'd0;
      end else begin
         case (state)
            IDLE: if (grant_d || grant_i) begin
               owner_d <= grant_d;
               m_addr  <= grant_d ? d_addr : i_addr;
               if (grant_d) m_wdata <= d_wdata;
               we_r    <= grant_d && d_we;
               err_r   <= req_err;
               rdata_r <= 32'd0;
               cnt     <= 4'd0;
               if (grant_d) data_streak <= (data_streak == 2'd2) ? 2'd2 : data_streak + 2'd1;
               else         data_streak <= 2'd0;
            end
            ACCESS: begin
               cnt <= cnt + 4'd1;
               if (cnt == LAST && !we_r) rdata_r <= m_rdata;
            end
            default: ;
         endcase
      end
   end

   // strobes decode straight from state so an async reset drops them at once
   assign m_read  = (state == ACCESS) && !we_r;
   assign m_write = (state == ACCESS) && we_r && (cnt == 4'd0);
   assign busy    = (state != IDLE);
   assign d_ack   = (state == RESP) && owner_d;
   assign i_ack   = (state == RESP) && !owner_d;
   assign d_err   = d_ack && err_r;
   assign i_err   = i_ack && err_r;
   assign d_rdata = d_ack ? rdata_r : 32'd0;
   assign i_rdata = i_ack ? rdata_r : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-addressed memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_ack, i_err, d_req, d_we, d_ack, d_err;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_read, m_write, busy;
   int          checks = 0;
   int          errors = 0;

   logic [31:0] mem [0:4095];

   mem_arbiter #(.LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
      .m_rdata(m_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   assign m_rdata = mem[m_addr[13:2]];
   always @(posedge clk) if (m_write) mem[m_addr[13:2]] <= m_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // single rejected access: ack must arrive the cycle after the sample edge
   task automatic err_step(input bit is_d, input logic [31:0] a);
      if (is_d) begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
      else      begin i_req = 1'b1; i_addr = a; end
      @(negedge clk);
      chk(is_d ? "err_d_ack" : "err_i_ack", {31'd0, is_d ? d_ack : i_ack}, 32'd1);
      chk(is_d ? "err_d_flag" : "err_i_flag", {31'd0, is_d ? d_err : i_err}, 32'd1);
      chk(is_d ? "err_d_rdata" : "err_i_rdata", is_d ? d_rdata : i_rdata, 32'd0);
      chk("err_no_mem", {30'd0, m_read, m_write}, 32'd0);
      d_req = 1'b0; i_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] exp_d;
      int         n;
      logic       saw_ack;

      for (int k = 0; k < 4096; k++) mem[k] = 32'd0;
      mem[32'h10 >> 2]   = 32'hDEAD_BEEF;
      mem[32'h3000 >> 2] = 32'hCAFE_F00D;
      reset = 1'b1; i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_acks", {30'd0, d_ack, i_ack}, 32'd0);
      chk("rst_maddr", m_addr, 32'd0);
      chk("rst_strobes", {30'd0, m_read, m_write}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // read 0x10
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      @(negedge clk);
      chk("rd_c1_mread", {31'd0, m_read}, 32'd1);
      chk("rd_c1_maddr", m_addr, 32'h10);
      chk("rd_c1_noack", {31'd0, d_ack}, 32'd0);
      @(negedge clk);
      chk("rd_c2_mread", {31'd0, m_read}, 32'd1);
      chk("rd_c2_noack", {31'd0, d_ack}, 32'd0);
      @(negedge clk);
      chk("rd_ack", {31'd0, d_ack}, 32'd1);
      chk("rd_data", d_rdata, 32'hDEAD_BEEF);
      chk("rd_err", {31'd0, d_err}, 32'd0);
      chk("rd_iack", {31'd0, i_ack}, 32'd0);
      chk("rd_resp_mread", {31'd0, m_read}, 32'd0);
      d_req = 1'b0;
      @(negedge clk);
      chk("rd_idle", {30'd0, busy, d_ack}, 32'd0);

      // write 0x20
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("wr_c1_strobes", {30'd0, m_read, m_write}, 32'd1);
      chk("wr_c1_maddr", m_addr, 32'h20);
      chk("wr_c1_mwdata", m_wdata, 32'h1234_5678);
      @(negedge clk);
      chk("wr_c2_strobes", {30'd0, m_read, m_write}, 32'd0);
      chk("wr_c2_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("wr_ack", {31'd0, d_ack}, 32'd1);
      chk("wr_rdata", d_rdata, 32'd0);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("wr_idle_maddr_hold", m_addr, 32'h20);

      // read back 0x20
      d_req = 1'b1; d_addr = 32'h20;
      repeat (3) @(negedge clk);
      chk("rb_ack", {31'd0, d_ack}, 32'd1);
      chk("rb_data", d_rdata, 32'h1234_5678);
      d_req = 1'b0;
      @(negedge clk);

      // reset during first ACCESS cycle of a write
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'hA5A5_A5A5;
      @(posedge clk);
      #1 chk("abort_pre_mwrite", {31'd0, m_write}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("abort_mwrite", {31'd0, m_write}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_maddr", m_addr, 32'd0);
      chk("abort_mwdata", m_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
      saw_ack = 1'b0;
      repeat (4) begin @(negedge clk); saw_ack |= d_ack; end
      chk("abort_no_ack", {31'd0, saw_ack}, 32'd0);
      chk("abort_no_memwrite", mem[32'h24 >> 2], 32'd0);

      // both held high: grant order D D I D D I (streak cleared by reset)
      exp_d = 6'b011011;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      i_req = 1'b1; i_addr = 32'h3000;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         @(negedge clk);
         while (!(d_ack || i_ack) && n < 12) begin @(negedge clk); n++; end
         chk("prio_ack_seen", {31'd0, d_ack || i_ack}, 32'd1);
         chk("prio_order", {31'd0, d_ack}, {31'd0, exp_d[k]});
         if (i_ack) chk("prio_irdata", i_rdata, 32'hCAFE_F00D);
         if (d_ack) chk("prio_drdata", d_rdata, 32'hDEAD_BEEF);
         chk("prio_no_err", {30'd0, d_err, i_err}, 32'd0);
      end
      d_req = 1'b0; i_req = 1'b0;
      repeat (2) @(negedge clk);

      // rejected accesses
      err_step(1'b0, 32'h3002);
      err_step(1'b0, 32'h2000);
      err_step(1'b0, 32'h4000);
      err_step(1'b1, 32'h3000);
      err_step(1'b1, 32'h11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
